// File: rtl/alu_writeback.sv
// Retirement stage for ALU results: 2-entry writeback FIFO feeding a register
// file and PSR, with bypassed read ports and pending-write hazard flags.
module alu_writeback #(
    parameter int WIDTH = 16,
    parameter int NREGS = 16,
    parameter int DEPTH = 2,
    localparam int AW = $clog2(NREGS)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_result,
    input  logic [AW-1:0]    in_dest,
    input  logic             in_wr_en,
    input  logic [4:0]       in_flags,
    input  logic [4:0]       in_flag_mask,
    input  logic             wb_stall,
    input  logic [AW-1:0]    rd_addr_a,
    input  logic [AW-1:0]    rd_addr_b,
    output logic [WIDTH-1:0] rd_data_a,
    output logic [WIDTH-1:0] rd_data_b,
    output logic             rd_pend_a,
    output logic             rd_pend_b,
    output logic [4:0]       psr,
    output logic [15:0]      retire_count
);

    logic [WIDTH-1:0] fifo_result_q [DEPTH];
    logic [WIDTH-1:0] fifo_result_d [DEPTH];
    logic [AW-1:0]    fifo_dest_q   [DEPTH];
    logic [AW-1:0]    fifo_dest_d   [DEPTH];
    logic             fifo_wr_en_q  [DEPTH];
    logic             fifo_wr_en_d  [DEPTH];
    logic [4:0]       fifo_flags_q  [DEPTH];
    logic [4:0]       fifo_flags_d  [DEPTH];
    logic [4:0]       fifo_mask_q   [DEPTH];
    logic [4:0]       fifo_mask_d   [DEPTH];

    logic             head_q, head_d;
    logic             tail_q, tail_d;
    logic [1:0]       count_q, count_d;
    logic [WIDTH-1:0] regs_q [NREGS];
    logic [WIDTH-1:0] regs_d [NREGS];
    logic [4:0]       psr_q, psr_d;
    logic [15:0]      retire_q, retire_d;

    logic             accept;
    logic             commit;
    logic             head_writes;
    logic [DEPTH-1:0] occ;

    // Ready comes from registered occupancy only, forced low while in reset.
    assign in_ready    = !reset && (count_q < 2'd2);
    assign accept      = in_valid && in_ready;
    assign commit      = (count_q != 2'd0) && !wb_stall;
    assign head_writes = commit && fifo_wr_en_q[head_q];

    assign psr          = psr_q;
    assign retire_count = retire_q;

    always_comb begin
        fifo_result_d = fifo_result_q;
        fifo_dest_d   = fifo_dest_q;
        fifo_wr_en_d  = fifo_wr_en_q;
        fifo_flags_d  = fifo_flags_q;
        fifo_mask_d   = fifo_mask_q;
        if (accept) begin
            fifo_result_d[tail_q] = in_result;
            fifo_dest_d[tail_q]   = in_dest;
            fifo_wr_en_d[tail_q]  = in_wr_en;
            fifo_flags_d[tail_q]  = in_flags;
            fifo_mask_d[tail_q]   = in_flag_mask;
        end
    end

    always_comb begin
        head_d   = head_q ^ commit;
        tail_d   = tail_q ^ accept;
        count_d  = count_q + {1'b0, accept} - {1'b0, commit};
        retire_d = retire_q + {15'd0, commit};
        psr_d    = psr_q;
        regs_d   = regs_q;
        if (commit) begin
            psr_d = (psr_q & ~fifo_mask_q[head_q]) | (fifo_flags_q[head_q] & fifo_mask_q[head_q]);
        end
        if (head_writes) begin
            regs_d[fifo_dest_q[head_q]] = fifo_result_q[head_q];
        end
    end

    // Slot i is live if the FIFO is full, or it is the head of a single entry.
    always_comb begin
        occ = '0;
        for (int i = 0; i < DEPTH; i++) begin
            occ[i] = (count_q == 2'd2) || ((count_q == 2'd1) && (head_q == 1'(i)));
        end
    end

    always_comb begin
        rd_pend_a = 1'b0;
        rd_pend_b = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            if (occ[i] && fifo_wr_en_q[i] && (fifo_dest_q[i] == rd_addr_a)) rd_pend_a = 1'b1;
            if (occ[i] && fifo_wr_en_q[i] && (fifo_dest_q[i] == rd_addr_b)) rd_pend_b = 1'b1;
        end
    end

    always_comb begin
        rd_data_a = regs_q[rd_addr_a];
        rd_data_b = regs_q[rd_addr_b];
        if (head_writes && (fifo_dest_q[head_q] == rd_addr_a)) rd_data_a = fifo_result_q[head_q];
        if (head_writes && (fifo_dest_q[head_q] == rd_addr_b)) rd_data_b = fifo_result_q[head_q];
    end

    // FIFO payload is only ever observed through occupied slots, so it is not reset.
    always_ff @(posedge clk) begin
        fifo_result_q <= fifo_result_d;
        fifo_dest_q   <= fifo_dest_d;
        fifo_wr_en_q  <= fifo_wr_en_d;
        fifo_flags_q  <= fifo_flags_d;
        fifo_mask_q   <= fifo_mask_d;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            head_q   <= 1'b0;
            tail_q   <= 1'b0;
            count_q  <= 2'd0;
            psr_q    <= 5'd0;
            retire_q <= 16'd0;
            for (int i = 0; i < NREGS; i++) regs_q[i] <= '0;
        end else begin
            head_q   <= head_d;
            tail_q   <= tail_d;
            count_q  <= count_d;
            psr_q    <= psr_d;
            retire_q <= retire_d;
            regs_q   <= regs_d;
        end
    end

endmodule

// File: tb/tb_alu_writeback.sv
// Randomized and directed bench for alu_writeback against a queue-based
// reference model of the writeback buffer, register file and PSR.
module tb_alu_writeback;

    logic        clk;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] in_result;
    logic [3:0]  in_dest;
    logic        in_wr_en;
    logic [4:0]  in_flags;
    logic [4:0]  in_flag_mask;
    logic        wb_stall;
    logic [3:0]  rd_addr_a, rd_addr_b;
    logic [15:0] rd_data_a, rd_data_b;
    logic        rd_pend_a, rd_pend_b;
    logic [4:0]  psr;
    logic [15:0] retire_count;

    alu_writeback #(.WIDTH(16), .NREGS(16), .DEPTH(2)) dut (
        .clk(clk), .reset(reset),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_result(in_result), .in_dest(in_dest), .in_wr_en(in_wr_en),
        .in_flags(in_flags), .in_flag_mask(in_flag_mask),
        .wb_stall(wb_stall),
        .rd_addr_a(rd_addr_a), .rd_addr_b(rd_addr_b),
        .rd_data_a(rd_data_a), .rd_data_b(rd_data_b),
        .rd_pend_a(rd_pend_a), .rd_pend_b(rd_pend_b),
        .psr(psr), .retire_count(retire_count)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        logic [15:0] res;
        logic [3:0]  dest;
        logic        we;
        logic [4:0]  fl;
        logic [4:0]  mk;
    } ent_t;

    ent_t        q[$];
    logic [15:0] m_regs [16];
    logic [4:0]  m_psr;
    logic [15:0] m_rc;
    bit          last_acc;

    int n_vec = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic void model_clear();
        q.delete();
        for (int i = 0; i < 16; i++) m_regs[i] = 16'd0;
        m_psr = 5'd0;
        m_rc  = 16'd0;
    endfunction

    function automatic logic [15:0] model_read(input logic [3:0] a, input bit com);
        if (com && q[0].we && q[0].dest == a) return q[0].res;
        return m_regs[a];
    endfunction

    function automatic logic model_pend(input logic [3:0] a);
        foreach (q[i]) if (q[i].we && q[i].dest == a) return 1'b1;
        return 1'b0;
    endfunction

    // One clock: compare outputs at negedge, then advance the model on posedge.
    task automatic step(input bit chk_en);
        bit   com, acc;
        ent_t e, h;
        @(negedge clk);
        com = (q.size() > 0) && !wb_stall;
        acc = in_valid && (q.size() < 2);
        if (chk_en) begin
            chk("in_ready", in_ready, q.size() < 2);
            chk("rd_data_a", rd_data_a, model_read(rd_addr_a, com));
            chk("rd_data_b", rd_data_b, model_read(rd_addr_b, com));
            chk("rd_pend_a", rd_pend_a, model_pend(rd_addr_a));
            chk("rd_pend_b", rd_pend_b, model_pend(rd_addr_b));
            chk("psr", psr, m_psr);
            chk("retire_count", retire_count, m_rc);
        end
        e.res = in_result; e.dest = in_dest; e.we = in_wr_en;
        e.fl = in_flags;   e.mk = in_flag_mask;
        @(posedge clk);
        if (com) begin
            h = q.pop_front();
            if (h.we) m_regs[h.dest] = h.res;
            m_psr = (m_psr & ~h.mk) | (h.fl & h.mk);
            m_rc  = m_rc + 16'd1;
        end
        if (acc) q.push_back(e);
        last_acc = acc;
        #1;
    endtask

    task automatic put(input logic [15:0] r, input logic [3:0] d, input logic we,
                       input logic [4:0] fl, input logic [4:0] mk);
        in_valid = 1'b1; in_result = r; in_dest = d; in_wr_en = we;
        in_flags = fl; in_flag_mask = mk;
    endtask

    task automatic drain();
        in_valid = 1'b0;
        wb_stall = 1'b0;
        for (int i = 0; i < 8 && q.size() > 0; i++) step(1);
    endtask

    task automatic apply_reset();
        reset = 1'b1; in_valid = 1'b0; wb_stall = 1'b0;
        model_clear();
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        #1;
        chk("ready_after_reset", in_ready, 1'b1);
        @(posedge clk);
        #1;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset = 1'b1; in_valid = 1'b0; in_result = '0; in_dest = '0; in_wr_en = 1'b0;
        in_flags = '0; in_flag_mask = '0; wb_stall = 1'b0; rd_addr_a = '0; rd_addr_b = '0;
        model_clear();
        #1;
        chk("ready_in_reset", in_ready, 1'b0);
        chk("psr_in_reset", psr, 5'd0);
        chk("rc_in_reset", retire_count, 16'd0);

        // Single result with bypass and pending.
        apply_reset();
        rd_addr_a = 4'd3;
        put(16'hFF2D, 4'd3, 1'b1, 5'b00010, 5'b11111);
        step(1);
        in_valid = 1'b0;
        chk("t1_pend_before", rd_pend_a, 1'b1);
        chk("t1_bypass", rd_data_a, 16'hFF2D);
        step(1);
        chk("t1_reg3", rd_data_a, 16'hFF2D);
        chk("t1_psr", psr, 5'b00010);
        chk("t1_rc", retire_count, 16'd1);
        chk("t1_pend_after", rd_pend_a, 1'b0);

        // Back-pressure under stall.
        apply_reset();
        wb_stall = 1'b1;
        put(16'h0A01, 4'd1, 1'b1, 5'd0, 5'd0); step(1);
        put(16'h0B02, 4'd2, 1'b1, 5'd0, 5'd0); step(1);
        chk("t2_full", in_ready, 1'b0);
        put(16'h0C07, 4'd7, 1'b1, 5'd0, 5'd0); step(1);
        step(1);
        wb_stall = 1'b0;
        for (int i = 0; i < 8; i++) begin
            step(1);
            if (last_acc) break;
        end
        drain();
        rd_addr_a = 4'd1; rd_addr_b = 4'd7;
        #1;
        chk("t2_rc", retire_count, 16'd3);
        chk("t2_r1", rd_data_a, 16'h0A01);
        chk("t2_r7", rd_data_b, 16'h0C07);

        // Partial PSR mask.
        put(16'h0, 4'd0, 1'b0, 5'b11111, 5'b11111); step(1);
        put(16'h0, 4'd0, 1'b0, 5'b00000, 5'b00001); step(1);
        drain();
        chk("t3_psr", psr, 5'b11110);

        // Same-destination ordering.
        rd_addr_b = 4'd5;
        put(16'h1111, 4'd5, 1'b1, 5'd0, 5'd0); step(1);
        put(16'h2222, 4'd5, 1'b1, 5'd0, 5'd0); step(1);
        in_valid = 1'b0;
        chk("t4_pend", rd_pend_b, 1'b1);
        step(1);
        chk("t4_pend_clear", rd_pend_b, 1'b0);
        chk("t4_r5", rd_data_b, 16'h2222);

        // Asynchronous reset with two buffered entries.
        put(16'hABCD, 4'd3, 1'b1, 5'b10101, 5'b11111); step(1);
        in_valid = 1'b0; step(1);
        wb_stall = 1'b1;
        put(16'h1234, 4'd3, 1'b1, 5'b01010, 5'b11111); step(1);
        put(16'h5678, 4'd4, 1'b1, 5'b01010, 5'b11111); step(1);
        in_valid = 1'b0;
        rd_addr_a = 4'd3;
        #3;
        reset = 1'b1;
        #1;
        chk("t5_ready", in_ready, 1'b0);
        chk("t5_psr", psr, 5'd0);
        chk("t5_rc", retire_count, 16'd0);
        chk("t5_pend", rd_pend_a, 1'b0);
        chk("t5_r3", rd_data_a, 16'd0);
        model_clear();
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b0; wb_stall = 1'b0;
        @(posedge clk);
        #1;
        step(1);
        chk("t5_r3_after", rd_data_a, 16'd0);
        chk("t5_rc_after", retire_count, 16'd0);

        // Randomized traffic against the model.
        for (int i = 0; i < 3000; i++) begin
            in_valid     = ($urandom_range(0, 9) < 7);
            wb_stall     = ($urandom_range(0, 9) < 3);
            in_result    = 16'($urandom);
            in_dest      = 4'($urandom_range(0, 3));
            in_wr_en     = ($urandom_range(0, 3) != 0);
            in_flags     = 5'($urandom);
            in_flag_mask = 5'($urandom);
            rd_addr_a    = 4'($urandom_range(0, 4));
            rd_addr_b    = 4'($urandom_range(0, 4));
            step(1);
        end
        drain();

        // NOP retirements wrap the retire counter.
        apply_reset();
        rd_addr_a = 4'd9; rd_addr_b = 4'd2;
        put(16'hBEEF, 4'd9, 1'b1, 5'b01101, 5'b11111); step(1);
        for (int i = 0; i < 65535; i++) begin
            put(16'($urandom), 4'($urandom), 1'b0, 5'($urandom), 5'd0);
            step(i % 4096 == 0);
        end
        drain();
        chk("t6_rc_wrap", retire_count, 16'h0000);
        chk("t6_psr", psr, 5'b01101);
        chk("t6_r9", rd_data_a, 16'hBEEF);
        chk("t6_r2", rd_data_b, 16'h0000);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/alu_writeback.md
Name: alu_writeback

Overview:
- Retirement end of the ALU interface. The ALU and its stimulus side produce C, Carry, Flag, Low, Negative and Zero; this block consumes that stream.
- Accepts ALU results through a valid/ready handshake and buffers them in a 2-entry FIFO.
- Commits each result in order into a 16x16 register file and the processor status register (PSR).
- Provides two read ports with write bypass and pending-hazard indication to the operand-fetch stage.

Parameters:
- WIDTH, 16, data width of results and registers
- NREGS, 16, number of architectural registers (address width = 4)
- DEPTH, 2, writeback FIFO entries (fixed at 2; other values unsupported)

Ports:
- clk  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-high reset
- in_valid  in  1  ALU result valid
- in_ready  out  1  block can accept a result this cycle
- in_result  in  16  ALU output C
- in_dest  in  4  destination register index
- in_wr_en  in  1  1 = write in_result to register file
- in_flags  in  5  {Carry,Flag,Low,Negative,Zero} from ALU
- in_flag_mask  in  5  per-bit PSR update enable, same bit order
- wb_stall  in  1  hold commit this cycle (write-port contention)
- rd_addr_a, rd_addr_b  in  4  read port addresses
- rd_data_a, rd_data_b  out  16  read port data (combinational)
- rd_pend_a, rd_pend_b  out  1  an uncommitted FIFO entry targets this address with wr_en=1
- psr  out  5  {C,F,L,N,Z} status register
- retire_count  out  16  number of committed entries, wraps 0xFFFF->0x0000

Behaviour:
- Reset (async, immediate):
  - all registers, psr, FIFO count, pointers and retire_count go to 0.
  - in_ready=0 while reset is high; in_ready=1 in the first cycle after deassertion.
- Accept: on a rising edge with in_valid&&in_ready, {result,dest,wr_en,flags,mask} is written to the FIFO tail.
  - in_ready = (count<2), registered state only; it never depends combinationally on in_valid or wb_stall.
- Commit: on a rising edge with count>0 && !wb_stall, the head entry retires.
  - regs[dest] <= result if wr_en.
  - psr[i] <= flags[i] where mask[i]=1; unmasked bits hold.
  - retire_count increments; the head pointer advances.
- Simultaneous accept and commit in the same edge: count is unchanged, and both operations occur.
  - With count==2, in_ready=0, so there is no accept that cycle even if a commit happens.
- Latency: a result accepted at edge N is committed at edge N+1 at the earliest. Each stall cycle adds one.
- Order: strictly FIFO. Two entries to the same dest or the same flags commit oldest first; the final state reflects the younger entry.
- Bypass: if the head is committing this cycle (count>0, !wb_stall, wr_en) and rd_addr matches its dest, rd_data returns head.result. Otherwise rd_data = regs[rd_addr].
- Pending: rd_pend_x=1 if any occupied entry has wr_en=1 and dest==rd_addr_x, including a head committing this cycle.
- in_wr_en=0 with in_flag_mask=0: the entry still occupies a slot and still increments retire_count (NOP retirement).
- wb_stall with count==0: no effect.
- Reset mid-operation: buffered entries are discarded, never committed, and the register file is cleared.
- No arithmetic on data: result is stored verbatim, with no sign or width change.

Test Plan:
1. Reset release, then one result: result=0xFF2D, dest=3, wr_en=1, flags=5'b00010, mask=5'b11111. Required: in_ready=1 the cycle after reset; next edge regs[3]=0xFF2D, psr=5'b00010, retire_count=1; rd_addr_a=3 returns 0xFF2D during the commit cycle (bypass), and rd_pend_a=1 before the commit.
2. Hold wb_stall=1 and present 3 results back to back. Required: the first two are accepted and in_ready=0 after the second; the third is held with in_valid high. Release the stall: commits occur in order, the third is accepted on the edge after count drops below 2, and retire_count=3.
3. Partial mask: psr=5'b11111, then an entry with flags=5'b00000, mask=5'b00001. Required: psr=5'b11110 after commit.
4. Same-dest ordering: dest=5 with result 0x1111, then dest=5 with 0x2222, no stall. Required: regs[5]=0x2222 after the second commit; rd_pend for r5 is 1 until then.
5. Assert reset asynchronously mid-cycle with 2 entries buffered. Required: outputs zero immediately, no commit occurs, and regs[3]=0 afterward.
6. Drive 65536 NOP entries (wr_en=0, mask=0). Required: retire_count wraps to 0x0000, and psr and registers are unchanged.
